poly_mult_seq: RTL and testbench
================================

Name: poly_mult_seq

Overview:
- Parametrised sequential polynomial multiplier: c = a·b in Z_(2^W)[x]/(x^N+1) (negacyclic) or /(x^N−1) (cyclic).
- Next-generation multiplier for the accelerated-multiplier datapath; generalises the fixed 4-coefficient, 4-bit form to N coefficients of W bits.
- Adds a start/busy/done handshake, with one operand column processed per cycle on N parallel MAC lanes.

Parameters:
- N, 4, number of coefficients per polynomial (≥2).
- W, 4, coefficient width in bits; the coefficient modulus is 2^W.
- CW, $clog2(N), width of the column counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- start  input  1  request; sampled only in IDLE or DONE.
- a_in  input  N*W  operand a; coefficient i at [i*W +: W], i=0 is x^0.
- b_in  input  N*W  operand b; same packing as a_in.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; c_out is valid from this cycle onward.
- c_out  output  N*W  result; same packing; held until the next done.

Behaviour:
- Reset (reset==0 at an edge):
  - State→IDLE; busy=0, done=0, c_out=0.
  - Accumulators, operand registers and counter j cleared.
  - Reset takes priority over every other event, including mid-RUN; an aborted operation never produces done.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a_in, b_in; clear accumulators; j=0; →RUN. Otherwise stay.
  - RUN: for every lane k, acc[k] += s·a[i]·b[j], where i=(k−j) mod N and s=−1 if k<j (wrap) under negacyclic, otherwise s=+1.
  - RUN: j increments each cycle. When j==N−1: c_out ← final acc values (including that cycle's term), →DONE.
  - DONE: done=1 for exactly one cycle. start=1 → accept a new operation exactly as in IDLE (back-to-back, no bubble). Otherwise →IDLE.
- Latency:
  - Start sampled at edge t → c_out updates at edge t+N; done is high in the cycle following edge t+N.
  - Throughput: one result per N+1 cycles.
- start during RUN is ignored; it is neither queued nor an error.
- a_in/b_in changes after the start edge have no effect (operands are latched).
- Arithmetic:
  - Each product is 2W bits, truncated to W.
  - Accumulation is mod 2^W (wrap, no saturation); subtraction is two's-complement mod 2^W.
- busy = (state==RUN); done = (state==DONE). Both are registered and glitch-free.

Optional Feature:
- Macro POLY_MULT_NEGACYCLIC_EN.
- Defined: reduction by x^N+1; wrapped terms are subtracted.
- Undefined: reduction by x^N−1 (cyclic convolution); wrapped terms are added.
- Ports and latency are identical in both builds.

Decomposition:
- Package poly_mult_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default N/W localparams;
  - coefficient slice helper macro/function for [i*W +: W].
- Sub-module coef_mac (W-bit): inputs acc, x, y, sub; output (acc ± x·y) mod 2^W.
  - Combinational; N instances in generate.
  - Control FSM, counter and the operand rotation/index logic stay in poly_mult_seq.

Test Plan (N=4, W=4, negacyclic unless noted; coefficient lists are [c0,c1,c2,c3]):
1. Identity: a=[1,0,0,0], b=[5,6,8,0], start at edge t → busy high for 4 cycles; done pulse after edge t+4; c_out=[5,6,8,0].
2. Square: a=b=[1,1,0,0] → c=[1,2,1,0]. Overflow case: a=[15,0,0,0], b=[15,0,0,0] → c=[1,0,0,0] (225 mod 16).
3. Wrap: a=[0,1,0,0], b=[0,0,0,1] (x·x^3) → negacyclic c=[15,0,0,0]; build without POLY_MULT_NEGACYCLIC_EN → c=[1,0,0,0].
4. Handshake:
   - start held high through RUN with a_in changing → no restart; result matches the operands latched at start.
   - start=1 in the DONE cycle → next done exactly 5 cycles after the previous one.
5. Reset mid-operation: reset=0 for one edge at RUN j=2 → busy=0, done=0, c_out=0 next cycle; no done pulse for 10 cycles. A subsequent start yields a correct result.
6. Randomised: 200 random (a,b) pairs with gaps → c_out compared against a software negacyclic mod-16 reference model; done count equals start-accept count.

Source files
------------

// File: rtl/poly_mult_pkg.sv
// Shared constants and helpers for the sequential polynomial multiplier.
// State encodings, default sizing and the coefficient slice helper.
package poly_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 4;

  // LSB position of coefficient idx in a flat vector packed as [idx*w +: w]
  function automatic int coef_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/coef_mac.sv
// Single-lane combinational multiply-accumulate: sum = (acc +/- x*y) mod 2^W.
// The product is truncated to W bits before it is accumulated.
module coef_mac #(
  parameter int W = 4
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   prod_low;

  assign prod     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
  assign prod_low = prod[W-1:0];
  assign sum      = sub ? (acc - prod_low) : (acc + prod_low);

endmodule

// File: rtl/poly_mult_seq.sv
// Sequential polynomial multiplier c = a*b over Z_(2^W)[x], one b column per cycle on N MAC lanes.
// Define POLY_MULT_NEGACYCLIC_EN for reduction by x^N+1; otherwise reduction is by x^N-1 (cyclic).
module poly_mult_seq
  import poly_mult_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int W  = DEFAULT_W,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] c_out
);

`ifdef POLY_MULT_NEGACYCLIC_EN
  localparam logic NEGACYCLIC = 1'b1;
`else
  localparam logic NEGACYCLIC = 1'b0;
`endif

  localparam logic [CW-1:0] J_LAST = CW'(N - 1);

  logic [1:0]           state;
  logic [CW-1:0]        j;
  logic [N*W-1:0]       a_reg;
  logic [N*W-1:0]       b_reg;
  logic [N*W-1:0]       acc;
  logic [N*W-1:0]       acc_next;
  logic [N-1:0][W-1:0]  x_sel;
  logic [N-1:0]         sub_sel;
  logic [W-1:0]         b_col;
  int                   idx;

  assign b_col = b_reg[coef_lsb(int'(j), W) +: W];

  // Lane k pairs b[j] with a[(k-j) mod N]; lanes below j received a wrapped term
  always_comb begin
    x_sel   = '0;
    sub_sel = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      if (k >= int'(j)) begin
        idx        = k - int'(j);
        sub_sel[k] = 1'b0;
      end else begin
        idx        = k - int'(j) + N;
        sub_sel[k] = NEGACYCLIC;
      end
      x_sel[k] = a_reg[coef_lsb(idx, W) +: W];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    coef_mac #(.W(W)) u_mac (
      .acc (acc[coef_lsb(k, W) +: W]),
      .x   (x_sel[k]),
      .y   (b_col),
      .sub (sub_sel[k]),
      .sum (acc_next[coef_lsb(k, W) +: W])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      j     <= '0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      c_out <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            acc   <= '0;
            j     <= '0;
            state <= ST_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          if (j == J_LAST) begin
            c_out <= acc_next;
            j     <= '0;
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_mult_seq.sv
// Self-checking bench for poly_mult_seq (N=4, W=4) using directed vectors plus a random sweep.
// Expected results follow the build: negacyclic when POLY_MULT_NEGACYCLIC_EN is defined, cyclic otherwise.
module tb_poly_mult_seq;

  localparam int N = 4;
  localparam int W = 4;

`ifdef POLY_MULT_NEGACYCLIC_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic           busy;
  logic           done;
  logic [N*W-1:0] c_out;

  int testsRun = 0;
  int testsFailed = 0;
  int doneCount = 0;
  int acceptCount = 0;
  int latency;

  poly_mult_seq #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) doneCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Schoolbook product with reduction applied to each term whose degree reaches N
  function automatic logic [N*W-1:0] polyRef(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    logic [W-1:0] c [N];
    logic [W-1:0] term;
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) c[k] = '0;
    for (int i = 0; i < N; i++) begin
      for (int jj = 0; jj < N; jj++) begin
        term = W'(a[i*W +: W] * b[jj*W +: W]);
        if (i + jj >= N && NEG) c[(i + jj) % N] = c[(i + jj) % N] - term;
        else                    c[(i + jj) % N] = c[(i + jj) % N] + term;
      end
    end
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = c[k];
    return r;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < 50) begin
      stepCycle();
      cycles++;
    end
    if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic [N*W-1:0] expected);
    applyStimulus(a, b);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    waitDone(latency);
    checkOutput({tag, "_latency"}, 32'(latency), 32'd4);
    checkOutput({tag, "_c"}, 32'(c_out), 32'(expected));
    stepCycle();
    checkOutput({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int gap;
    logic [N*W-1:0] ra, rb;

    reset = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_c", 32'(c_out), 32'd0);

    runOp("identity", 16'h0001, 16'h0865, 16'h0865);
    runOp("square", 16'h0011, 16'h0011, 16'h0121);
    runOp("overflow", 16'h000F, 16'h000F, 16'h0001);
    runOp("wrap", 16'h0010, 16'h1000, NEG ? 16'h000F : 16'h0001);
    runOp("mixed", 16'h4321, 16'h1111, NEG ? 16'hA2C8 : 16'hAAAA);

    // start held high through RUN while operands keep changing
    a_in  = 16'h0001;
    b_in  = 16'h0865;
    start = 1'b1;
    stepCycle();
    for (int n = 0; n < 3; n++) begin
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      stepCycle();
    end
    stepCycle();
    start = 1'b0;
    checkOutput("hold_done", 32'(done), 32'd1);
    checkOutput("hold_c", 32'(c_out), 32'h0865);
    stepCycle();
    checkOutput("hold_idle", 32'(busy), 32'd0);

    // back-to-back: new start accepted in the DONE cycle
    applyStimulus(16'h0011, 16'h0011);
    waitDone(latency);
    a_in  = 16'h4321;
    b_in  = 16'h1111;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    waitDone(latency);
    checkOutput("b2b_gap", 32'(latency + 1), 32'd5);
    checkOutput("b2b_c", 32'(c_out), NEG ? 32'hA2C8 : 32'hAAAA);
    stepCycle();

    // reset asserted for one edge while RUN is at j=2
    applyStimulus(16'h4321, 16'h1111);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    reset = 1'b1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_c", 32'(c_out), 32'd0);
    doneCount = 0;
    for (int n = 0; n < 10; n++) stepCycle();
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);
    runOp("after_abort", 16'h4321, 16'h1111, NEG ? 16'hA2C8 : 16'hAAAA);

    doneCount = 0;
    acceptCount = 0;
    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus(ra, rb);
      acceptCount++;
      waitDone(latency);
      checkOutput("random_c", 32'(c_out), 32'(polyRef(ra, rb)));
      gap = $urandom_range(3, 1);
      for (int g = 0; g < gap; g++) stepCycle();
    end
    checkOutput("random_count", 32'(doneCount), 32'(acceptCount));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
